// File: rtl/reset_sequencer_pkg.sv
// reset_sequencer_pkg
//   Shared types and helpers for the reset sequencer.
//   rs_state_t : sequencer FSM states.
//   REQ_CNT_W  : width of the saturating request counter.
//   ctr_width  : width needed for the stretch/gap/stage counters.
package reset_sequencer_pkg;

  typedef enum logic [1:0] {
    ASSERT  = 2'd0,
    RELEASE = 2'd1,
    DONE    = 2'd2,
    IDLE    = 2'd3
  } rs_state_t;

  localparam int REQ_CNT_W = 8;

  // One counter width serves all three counters; sized so the largest
  // reload value fits.
  function automatic int ctr_width(input int stretch, input int gap, input int stages);
    int m;
    m = stretch;
    if (gap > m) m = gap;
    if (stages > m) m = stages;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/reset_sequencer_sync_cell.sv
// sync_cell
//   SYNC_DEPTH-flop synchronizer chain, async reset to 0.
//   clk, rst : clock and async active-high reset
//   d_i      : asynchronous input
//   q_o      : synchronized output (last flop of the chain)
module sync_cell #(
  parameter int SYNC_DEPTH = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic [SYNC_DEPTH-1:0] sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[SYNC_DEPTH-2:0], d_i};
  end

  assign q_o = sync_q[SYNC_DEPTH-1];

endmodule

// File: rtl/reset_sequencer.sv
// reset_sequencer
//   Turns a narrow/asynchronous reset request into a stretched reset with
//   staged, synchronous release.
//   clk        : sole clock
//   rst        : async active-high power-on reset (starts a full sequence)
//   req_i      : async reset request, any pulse width
//   rst_o      : staged active-high resets, bit 0 releases first
//   busy_o     : high while the sequence is not idle
//   done_o     : one-cycle pulse after the last stage releases
//   req_cnt_o  : saturating count of synchronized request rising edges
module reset_sequencer
  import reset_sequencer_pkg::*;
#(
  parameter int STRETCH_CYCLES = 16,
  parameter int NUM_STAGES     = 3,
  parameter int STAGE_GAP      = 4,
  parameter int SYNC_DEPTH     = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_i,
  output logic [NUM_STAGES-1:0] rst_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [REQ_CNT_W-1:0]  req_cnt_o
);

  localparam int CW = ctr_width(STRETCH_CYCLES, STAGE_GAP, NUM_STAGES);
  localparam logic [CW-1:0] CNT_RELOAD = CW'(STRETCH_CYCLES - 1);
  localparam logic [CW-1:0] GAP_RELOAD = CW'(STAGE_GAP - 1);
  localparam logic [CW-1:0] LAST_STG   = CW'(NUM_STAGES - 1);

  rs_state_t             state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [CW-1:0]         gap_q, gap_d;
  logic [CW-1:0]         stg_q, stg_d;
  logic [NUM_STAGES-1:0] rst_q, rst_d;
  logic                  busy_q, done_q;
  logic [REQ_CNT_W-1:0]  req_cnt_q;
  logic                  cap_q;
  logic                  req_sync, req_sync_dly_q, req_rise;

  // Capture flop: any high level on req_i, however short, sets it
  // immediately. It is cleared only once the request has made it through
  // the synchronizer, and a still-high req_i keeps it set. This is the
  // async endpoint of the block.
  always_ff @(posedge clk or posedge rst or posedge req_i) begin
    if (rst)           cap_q <= 1'b0;
    else if (req_i)    cap_q <= 1'b1;
    else if (req_sync) cap_q <= 1'b0;
  end

  sync_cell #(.SYNC_DEPTH(SYNC_DEPTH)) u_sync (
    .clk (clk),
    .rst (rst),
    .d_i (cap_q),
    .q_o (req_sync)
  );

  assign req_rise = req_sync & ~req_sync_dly_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gap_d   = gap_q;
    stg_d   = stg_q;
    rst_d   = rst_q;
    case (state_q)
      ASSERT: begin
        if (cnt_q == '0) begin
          // Stages release in order, so clearing bit stg is a shift-in of 0.
          rst_d   = rst_q << 1;
          gap_d   = GAP_RELOAD;
          stg_d   = CW'(1);
          state_d = (NUM_STAGES == 1) ? DONE : RELEASE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RELEASE: begin
        if (gap_q == '0) begin
          rst_d = rst_q << 1;
          gap_d = GAP_RELOAD;
          stg_d = stg_q + 1'b1;
          if (stg_q == LAST_STG) state_d = DONE;
        end else begin
          gap_d = gap_q - 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      IDLE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // A synchronized request restarts the whole sequence from any state.
    if (req_sync) begin
      state_d = ASSERT;
      cnt_d   = CNT_RELOAD;
      rst_d   = '1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ASSERT;
      cnt_q          <= CNT_RELOAD;
      gap_q          <= '0;
      stg_q          <= '0;
      rst_q          <= '1;
      busy_q         <= 1'b1;
      done_q         <= 1'b0;
      req_cnt_q      <= '0;
      req_sync_dly_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      gap_q          <= gap_d;
      stg_q          <= stg_d;
      rst_q          <= rst_d;
      busy_q         <= (state_d != IDLE);
      done_q         <= (state_d == DONE);
      req_sync_dly_q <= req_sync;
      if (req_rise && (req_cnt_q != '1)) req_cnt_q <= req_cnt_q + 1'b1;
    end
  end

  assign rst_o     = rst_q;
  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign req_cnt_o = req_cnt_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer
//   Self-checking bench. The reference model is a timeline: each request
//   defines the first/last edge at which the sequencer sees it, and all
//   outputs after edge n follow from the last such edge L by arithmetic
//   (stage k released once n >= L + STRETCH + k*GAP).
module tb_reset_sequencer;

  localparam int S    = 16;
  localparam int NS   = 3;
  localparam int G    = 4;
  localparam int SD   = 2;
  localparam int NONE = 32'h7fff_ffff;
  localparam int HELD = 32'h3fff_ffff;

  typedef logic [NS+9:0] obs_t;   // {rst_o, done_o, busy_o, req_cnt_o}

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          req_i = 1'b0;
  logic [NS-1:0] rst_o;
  logic          busy_o, done_o;
  logic [7:0]    req_cnt_o;

  int n_chk  = 0;
  int n_fail = 0;
  int ecnt   = 0;

  // Model state: L of the previous request, pending request window, count.
  int last_prev = 0;
  int p_first   = NONE;
  int p_last    = NONE;
  int committed = 0;

  reset_sequencer #(
    .STRETCH_CYCLES (S),
    .NUM_STAGES     (NS),
    .STAGE_GAP      (G),
    .SYNC_DEPTH     (SD)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_i     (req_i),
    .rst_o     (rst_o),
    .busy_o    (busy_o),
    .done_o    (done_o),
    .req_cnt_o (req_cnt_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) ecnt <= ecnt + 1;

  // Expected outputs after edge n.
  function automatic obs_t model(int n);
    int L, c, rel;
    logic [NS-1:0] r;
    logic act;
    act = (n >= p_first);
    L   = act ? p_last : last_prev;
    c   = committed + (act ? 1 : 0);
    if (c > 255) c = 255;
    for (int k = 0; k < NS; k++) r[k] = (n < L + S + k * G);
    rel = L + S + (NS - 1) * G;
    return {r, (n == rel), (n <= rel), c[7:0]};
  endfunction

  // Drive one request pulse of w time units starting 1 after the current
  // negedge, and record when the sequencer will first/last see it.
  task automatic drive_pulse(int w);
    int a;
    #1;
    a = ecnt + 1;
    if (p_first != NONE) begin
      last_prev = p_last;
      committed = (committed < 255) ? committed + 1 : 255;
    end
    p_first = a + SD;
    p_last  = HELD;
    req_i   = 1'b1;
    #(w);
    req_i  = 1'b0;
    p_last = (((ecnt + 1) > (a + SD)) ? (ecnt + 1) : (a + SD)) + SD;
  endtask

  function automatic int pick_width();
    int w;
    w = $urandom_range(1, 80);
    if ((w % 10 == 4) || (w % 10 == 9)) w++;   // keep the fall off clock edges
    return w;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    #3;
    n_chk++; if (rst_o !== {NS{1'b1}}) begin n_fail++; $display("FAIL reset_rst_o got %b exp %b", rst_o, {NS{1'b1}}); end
    n_chk++; if (busy_o !== 1'b1) begin n_fail++; $display("FAIL reset_busy got %b exp 1", busy_o); end
    n_chk++; if (done_o !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b exp 0", done_o); end
    n_chk++; if (req_cnt_o !== 8'd0) begin n_fail++; $display("FAIL reset_cnt got %0d exp 0", req_cnt_o); end
    repeat (5) @(negedge clk);
    n_chk++;
    if ({rst_o, done_o, busy_o, req_cnt_o} !== {{NS{1'b1}}, 1'b0, 1'b1, 8'd0}) begin
      n_fail++; $display("FAIL reset_hold got %b", {rst_o, done_o, busy_o, req_cnt_o});
    end
  endtask

  task automatic test_power_on();
    obs_t e_v, a_v;
    int dn = 0;
    rst = 1'b0;
    last_prev = ecnt; p_first = NONE; p_last = NONE; committed = 0;
    repeat (S + (NS - 1) * G + 6) begin
      @(negedge clk);
      e_v = model(ecnt); a_v = {rst_o, done_o, busy_o, req_cnt_o};
      dn += int'(done_o);
      n_chk++; if (a_v !== e_v) begin n_fail++; $display("FAIL power_on n=%0d got %b exp %b", ecnt, a_v, e_v); end
    end
    n_chk++; if (dn != 1) begin n_fail++; $display("FAIL power_on_done_count got %0d exp 1", dn); end
  endtask

  task automatic test_glitch();
    obs_t e_v, a_v;
    drive_pulse(2);
    repeat (S + (NS - 1) * G + 10) begin
      @(negedge clk);
      e_v = model(ecnt); a_v = {rst_o, done_o, busy_o, req_cnt_o};
      n_chk++; if (a_v !== e_v) begin n_fail++; $display("FAIL glitch n=%0d got %b exp %b", ecnt, a_v, e_v); end
    end
    n_chk++; if (req_cnt_o !== 8'd1) begin n_fail++; $display("FAIL glitch_cnt got %0d exp 1", req_cnt_o); end
  endtask

  task automatic test_long();
    obs_t e_v, a_v;
    fork drive_pulse(100); join_none
    repeat (S + (NS - 1) * G + 20) begin
      @(negedge clk);
      e_v = model(ecnt); a_v = {rst_o, done_o, busy_o, req_cnt_o};
      n_chk++; if (a_v !== e_v) begin n_fail++; $display("FAIL long n=%0d got %b exp %b", ecnt, a_v, e_v); end
    end
    n_chk++; if (req_cnt_o !== 8'd2) begin n_fail++; $display("FAIL long_cnt got %0d exp 2", req_cnt_o); end
  endtask

  task automatic test_restart();
    obs_t e_v, a_v;
    int guard = 0;
    int dn = 0;
    drive_pulse(2);
    do begin
      @(negedge clk);
      e_v = model(ecnt); a_v = {rst_o, done_o, busy_o, req_cnt_o};
      dn += int'(done_o);
      n_chk++; if (a_v !== e_v) begin n_fail++; $display("FAIL restart_pre n=%0d got %b exp %b", ecnt, a_v, e_v); end
      guard++;
    end while ((rst_o !== 3'b100) && (guard < 100));
    n_chk++; if (rst_o !== 3'b100) begin n_fail++; $display("FAIL restart_wait got %b exp 100", rst_o); end
    drive_pulse(3);
    repeat (S + (NS - 1) * G + 10) begin
      @(negedge clk);
      e_v = model(ecnt); a_v = {rst_o, done_o, busy_o, req_cnt_o};
      dn += int'(done_o);
      n_chk++; if (a_v !== e_v) begin n_fail++; $display("FAIL restart n=%0d got %b exp %b", ecnt, a_v, e_v); end
    end
    n_chk++; if (dn != 1) begin n_fail++; $display("FAIL restart_done_count got %0d exp 1", dn); end
  endtask

  task automatic test_random();
    obs_t e_v, a_v;
    for (int i = 0; i < 24; i++) begin
      int w;
      int idle;
      w    = pick_width();
      idle = $urandom_range(0, 40);
      fork drive_pulse(w); join_none
      repeat (w / 10 + 6 + idle) begin
        @(negedge clk);
        e_v = model(ecnt); a_v = {rst_o, done_o, busy_o, req_cnt_o};
        n_chk++; if (a_v !== e_v) begin n_fail++; $display("FAIL random n=%0d w=%0d got %b exp %b", ecnt, w, a_v, e_v); end
      end
    end
  endtask

  task automatic test_saturation();
    obs_t e_v, a_v;
    for (int i = 0; i < 260; i++) begin
      drive_pulse(2);
      repeat (6) begin
        @(negedge clk);
        e_v = model(ecnt); a_v = {rst_o, done_o, busy_o, req_cnt_o};
        n_chk++; if (a_v !== e_v) begin n_fail++; $display("FAIL saturation n=%0d got %b exp %b", ecnt, a_v, e_v); end
      end
    end
    n_chk++; if (req_cnt_o !== 8'd255) begin n_fail++; $display("FAIL saturation_cnt got %0d exp 255", req_cnt_o); end
  endtask

  task automatic test_rst_mid_release();
    obs_t e_v, a_v;
    int guard = 0;
    drive_pulse(2);
    do begin
      @(negedge clk);
      guard++;
    end while ((rst_o !== 3'b110) && (guard < 100));
    n_chk++; if (rst_o !== 3'b110) begin n_fail++; $display("FAIL rst_mid_wait got %b exp 110", rst_o); end
    #2 rst = 1'b1;
    #1;
    n_chk++;
    if ({rst_o, done_o, busy_o, req_cnt_o} !== {{NS{1'b1}}, 1'b0, 1'b1, 8'd0}) begin
      n_fail++; $display("FAIL rst_mid_async got %b", {rst_o, done_o, busy_o, req_cnt_o});
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    last_prev = ecnt; p_first = NONE; p_last = NONE; committed = 0;
    repeat (S + (NS - 1) * G + 6) begin
      @(negedge clk);
      e_v = model(ecnt); a_v = {rst_o, done_o, busy_o, req_cnt_o};
      n_chk++; if (a_v !== e_v) begin n_fail++; $display("FAIL rst_mid_seq n=%0d got %b exp %b", ecnt, a_v, e_v); end
    end
  endtask

  initial begin
    test_reset();
    test_power_on();
    test_glitch();
    test_long();
    test_restart();
    test_random();
    test_saturation();
    test_rst_mid_release();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    n_fail++;
    $display("FAIL watchdog time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
